// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the FIFO entry type for the register writeback path
package wb_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry FIFO with two ordered push ports (a lands before b) and one pop port
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_a,
    input  wb_entry_t              entry_a,
    input  logic                   push_b,
    input  wb_entry_t              entry_b,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_b;
    assign wr_b = push_a ? wr_ptr + AW'(1) : wr_ptr;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr] <= entry_a;
        if (push_b) mem[wr_b] <= entry_b;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and load results into one registered regfile write port.
// Optional busy scoreboard and decode stall under REG_WRITEBACK_SCOREBOARD_EN.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  wen,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_wdata,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  stall
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0] count;
    wb_entry_t     head, lsu_entry, alu_entry;
    logic          ready, lsu_push, alu_push, pop;
    // Two free slots guarantee both sources can land in the same cycle
    assign ready     = rst_n && count <= CW'(DEPTH - 2);
    assign alu_ready = ready;
    assign lsu_ready = ready;
    assign lsu_push  = lsu_valid && ready && lsu_rd != '0;
    assign alu_push  = alu_valid && ready && alu_rd != '0;
    assign lsu_entry = {lsu_rd, lsu_data};
    assign alu_entry = {alu_rd, alu_data};
    assign pop       = count != '0;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_a  (lsu_push),
        .entry_a (lsu_entry),
        .push_b  (alu_push),
        .entry_b (alu_entry),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen      <= 1'b0;
            rd_addr  <= '0;
            rd_wdata <= '0;
        end else begin
            wen <= pop;
            if (pop) begin
                rd_addr  <= head.rd;
                rd_wdata <= head.data;
            end
        end
    end
`ifdef REG_WRITEBACK_SCOREBOARD_EN
    logic [31:1] busy, set_mask, clr_mask;
    logic [31:0] busy_x;
    assign set_mask = (issue_valid && issue_rd != '0) ? 31'(1) << (issue_rd - 5'd1) : '0;
    assign clr_mask = (wen && rd_addr != '0) ? 31'(1) << (rd_addr - 5'd1) : '0;
    assign busy_x   = {busy, 1'b0};
    assign stall    = busy_x[rs1_addr] | busy_x[rs2_addr] | busy_x[issue_rd];
    // Set is applied after clear so a same-edge reissue keeps the register busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else busy <= (busy & ~clr_mask) | set_mask;
    end
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};
    assign stall = 1'b0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: randomized and directed checks of reg_writeback against a queue-based model
module tb_reg_writeback;
    localparam int DEPTH = 4;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        alu_valid = 0, lsu_valid = 0, issue_valid = 0;
    logic [4:0]  alu_rd = 0, lsu_rd = 0, issue_rd = 0, rs1_addr = 0, rs2_addr = 0;
    logic [31:0] alu_data = 0, lsu_data = 0;
    logic        alu_ready, lsu_ready, wen, stall;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wen(wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall)
    );

    int          vectors = 0, miscompares = 0;
    logic [36:0] q[$];
    logic        exp_wen = 0;
    logic [4:0]  exp_addr = 0;
    logic [31:0] exp_data = 0;
    logic [31:0] busy = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(logic av, logic [4:0] ard, logic [31:0] ad, logic lv, logic [4:0] lrd,
                         logic [31:0] ld, logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2);
        logic        rdy, exp_stall;
        logic [36:0] e;
        @(negedge clk);
        check("wen", 32'(wen), 32'(exp_wen));
        check("rd_addr", 32'(rd_addr), 32'(exp_addr));
        check("rd_wdata", rd_wdata, exp_data);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        issue_valid = iv; issue_rd = ird; rs1_addr = r1; rs2_addr = r2;
        #1;
        rdy = (DEPTH - q.size()) >= 2;
`ifdef REG_WRITEBACK_SCOREBOARD_EN
        exp_stall = busy[r1] | busy[r2] | busy[ird];
`else
        exp_stall = 1'b0;
`endif
        check("alu_ready", 32'(alu_ready), 32'(rdy));
        check("lsu_ready", 32'(lsu_ready), 32'(rdy));
        check("stall", 32'(stall), 32'(exp_stall));
        // Model of the coming edge: commit clears, issue sets, pop oldest, then push lsu before alu
        if (exp_wen) busy[exp_addr] = 1'b0;
        if (iv) busy[ird] = 1'b1;
        busy[0] = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            exp_wen = 1'b1; exp_addr = e[36:32]; exp_data = e[31:0];
        end else exp_wen = 1'b0;
        if (rdy && lv && lrd != 0) q.push_back({lrd, ld});
        if (rdy && av && ard != 0) q.push_back({ard, ad});
    endtask

    task automatic idle(int n, logic [4:0] r1 = 0);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        alu_valid = 0; lsu_valid = 0; issue_valid = 0;
        #1;
        check("rst_wen", 32'(wen), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_rd_wdata", rd_wdata, 0);
        check("rst_alu_ready", 32'(alu_ready), 0);
        check("rst_lsu_ready", 32'(lsu_ready), 0);
        check("rst_stall", 32'(stall), 0);
        q.delete(); exp_wen = 0; exp_addr = 0; exp_data = 0; busy = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // single ALU write, two-edge latency
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // same-cycle LSU and ALU: x3 then x4
        cycle(1, 4, 32'h22, 1, 3, 32'h11, 0, 0, 0, 0);
        idle(4);
        // x0 write completes handshake but never reaches the port
        cycle(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // both sources continuously valid: ready drops, nothing lost
        for (int i = 0; i < 8; i++)
            cycle(1, 5'(10 + i), 32'h100 + i, 1, 5'(20 + i), 32'h200 + i, 0, 0, 0, 0);
        idle(8);
        // scoreboard: issue x7, hold rs1=7 until commit, then same-edge reissue
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        idle(2, 7);
        cycle(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
        idle(1, 7);
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(2, 7);
        cycle(1, 7, 32'h78, 0, 0, 0, 0, 0, 7, 0);
        idle(4, 7);
        // reset with three entries queued and a busy register
        cycle(1, 4, 32'hA4, 1, 3, 32'hA3, 1, 9, 9, 0);
        cycle(1, 6, 32'hA6, 1, 5, 32'hA5, 0, 0, 9, 0);
        do_reset();
        idle(5, 9);
        // randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            cycle($urandom_range(0, 2) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end
        idle(8);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
